// File: rtl/aes_ctr_pad_gen.sv
// aes_ctr_pad_gen: counter-mode feeder and pad collector for a fixed-latency,
// non-stalling 128-bit AES pipeline. Credits bound the number of in-flight
// blocks so every pad that leaves the core always has a FIFO slot waiting.
module aes_ctr_pad_gen #(
    parameter int AES_LAT    = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [127:0]     req_iv,
    input  logic [127:0]     req_key,
    input  logic [CNT_W-1:0] req_count,
    output logic [127:0]     aes_state,
    output logic [127:0]     aes_key,
    input  logic [127:0]     aes_out,
    output logic             pad_valid,
    input  logic             pad_ready,
    output logic [127:0]     pad_data,
    output logic             pad_last,
    output logic             busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                r_state;
    logic [127:0]          r_ctr;
    logic [127:0]          r_key;
    logic [CNT_W-1:0]      r_rem;
    logic [127:0]          r_aes_state;
    logic [127:0]          r_aes_key;
    logic                  r_iss;
    logic                  r_iss_last;
    logic [AES_LAT:1]      r_dl_vld;
    logic [AES_LAT:1]      r_dl_last;
    logic [CW-1:0]         r_credits;
    logic [CW-1:0]         r_occ;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [127:0]          r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;

    logic w_issue;
    logic w_wr;
    logic w_pop;

    assign w_issue = (r_state == S_ISSUE) && (r_credits != '0);
    assign w_wr    = r_dl_vld[AES_LAT];
    assign w_pop   = pad_valid && pad_ready;

    // Request FSM: accepts a request, then streams counter blocks into the core
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_key       <= '0;
            r_rem       <= '0;
            r_aes_state <= '0;
            r_aes_key   <= '0;
            r_iss       <= 1'b0;
            r_iss_last  <= 1'b0;
        end else begin
            r_iss      <= 1'b0;
            r_iss_last <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_ctr <= req_iv;
                        r_key <= req_key;
                        r_rem <= req_count;
                        // A zero-length request completes in the handshake alone
                        if (req_count != '0)
                            r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_aes_state <= r_ctr;
                        r_aes_key   <= r_key;
                        r_iss       <= 1'b1;
                        r_iss_last  <= (r_rem == CNT_W'(1));
                        // Only the low 64 bits count; the upper half is a fixed nonce
                        r_ctr       <= {r_ctr[127:64], r_ctr[63:0] + 64'd1};
                        r_rem       <= r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1))
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Delay line tracking {valid, last} through the core latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_vld  <= '0;
            r_dl_last <= '0;
        end else begin
            r_dl_vld[1]  <= r_iss;
            r_dl_last[1] <= r_iss_last;
            for (int k = 2; k <= AES_LAT; k++) begin
                r_dl_vld[k]  <= r_dl_vld[k-1];
                r_dl_last[k] <= r_dl_last[k-1];
            end
        end
    end

    // Credits: one per free FIFO slot not already claimed by an in-flight block
    always_ff @(posedge clk) begin
        if (rst)
            r_credits <= CW'(FIFO_DEPTH);
        else if (w_issue && !w_pop)
            r_credits <= r_credits - CW'(1);
        else if (w_pop && !w_issue)
            r_credits <= r_credits + CW'(1);
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_wr && !w_pop)
                r_occ <= r_occ + CW'(1);
            else if (w_pop && !w_wr)
                r_occ <= r_occ - CW'(1);
        end
    end

    // FIFO storage; contents are masked at the outputs while empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_data[r_wptr] <= aes_out;
            r_mem_last[r_wptr] <= r_dl_last[AES_LAT];
        end
    end

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign aes_state = r_aes_state;
    assign aes_key   = r_aes_key;
    assign pad_valid = (r_occ != '0);
    assign pad_data  = pad_valid ? r_mem_data[r_rptr] : '0;
    assign pad_last  = pad_valid && r_mem_last[r_rptr];
    assign busy      = (r_state != S_IDLE) || r_iss || (|r_dl_vld) || pad_valid;

endmodule

// File: tb/tb_aes_ctr_pad_gen.sv
// tb_aes_ctr_pad_gen: drives counter-mode requests into aes_ctr_pad_gen with an
// 11-stage reference AES-128 core model and scoreboards every emitted pad.
module tb_aes_ctr_pad_gen;
    localparam int AES_LAT    = 11;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [127:0]     req_iv;
    logic [127:0]     req_key;
    logic [CNT_W-1:0] req_count;
    logic [127:0]     aes_state;
    logic [127:0]     aes_key;
    logic [127:0]     aes_out;
    logic             pad_valid;
    logic             pad_ready;
    logic [127:0]     pad_data;
    logic             pad_last;
    logic             busy;

    aes_ctr_pad_gen #(
        .AES_LAT   (AES_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_iv   (req_iv),
        .req_key  (req_key),
        .req_count(req_count),
        .aes_state(aes_state),
        .aes_key  (aes_key),
        .aes_out  (aes_out),
        .pad_valid(pad_valid),
        .pad_ready(pad_ready),
        .pad_data (pad_data),
        .pad_last (pad_last),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } exp_t;

    typedef struct packed {
        logic [127:0] iv;
        logic [127:0] key;
        logic [15:0]  cnt;
        logic [127:0] exp_last_state;
    } vec_t;

    exp_t sb[$];

    // ---------------- reference AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    initial begin : build_sbox
        logic [7:0] p;
        for (int x = 0; x < 256; x++) begin
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
            sbox[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[st[127-8*i -: 8]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) n[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // Core model: 11 register stages, aes_out follows aes_state by AES_LAT cycles
    logic [127:0] core_pipe [AES_LAT];
    always @(posedge clk) begin
        core_pipe[0] <= aes_enc(aes_state, aes_key);
        for (int k = 1; k < AES_LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign aes_out = core_pipe[AES_LAT-1];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ctr_add(input logic [127:0] iv, input int i);
        return {iv[127:64], iv[63:0] + 64'(i)};
    endfunction

    task automatic push_exp(input logic [127:0] iv, input logic [127:0] key, input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.data = aes_enc(ctr_add(iv, i), key);
            e.last = (i == cnt - 1);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the handshake edge with req_valid dropped
    task automatic do_req(input logic [127:0] iv, input logic [127:0] key, input int cnt);
        int n;
        n = 0;
        req_iv    = iv;
        req_key   = key;
        req_count = CNT_W'(cnt);
        req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            step();
            n++;
        end
        chk("req_accept", {127'd0, req_ready}, 128'd1);
        push_exp(iv, key, cnt);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || !req_ready) && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, {127'd0, busy}, 128'd0);
        chk({tag, "_sb_empty"}, 128'(sb.size()), 128'd0);
    endtask

    // Scoreboard consumer: compares each accepted pad against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && pad_valid && pad_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pad actual=%h required=none", pad_data);
            end else begin
                e = sb.pop_front();
                chk("pad_data", pad_data, e.data);
                chk("pad_last", {127'd0, pad_last}, {127'd0, e.last});
            end
        end
    end

    // FIFO must never be written while full
    always @(negedge clk) begin
        if (!rst && int'(dut.r_occ) == FIFO_DEPTH && dut.w_wr && !dut.w_pop) begin
            errors++;
            $display("FAIL fifo_overflow actual=write_when_full required=no_write");
        end
    end

    // ---------------- test sequence ----------------
    initial begin : main
        vec_t         vt [5];
        logic [127:0] fips_key, fips_iv, iv, prev, exp_hold;
        int           lat, n, issues, seen;

        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
        fips_iv  = 128'h00112233445566778899aabbccddeeff;
        vt[0] = '{fips_iv, fips_key, 16'd1, fips_iv};
        vt[1] = '{128'hA5A5A5A5A5A5A5A5_FFFFFFFFFFFFFFFE, fips_key, 16'd3,
                  128'hA5A5A5A5A5A5A5A5_0000000000000000};
        vt[2] = '{128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 16'd5, 128'h4};
        vt[3] = '{128'h123456789ABCDEF0_00000000FFFFFFFF, 128'h1, 16'd2,
                  128'h123456789ABCDEF0_0000000100000000};
        vt[4] = '{{128{1'b1}}, 128'hDEADBEEF, 16'd2, 128'hFFFFFFFFFFFFFFFF_0000000000000000};

        rst = 1'b1; req_valid = 1'b0; req_iv = '0; req_key = '0; req_count = '0;
        pad_ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
        chk("rst_pad_valid", {127'd0, pad_valid}, 128'd0);
        chk("rst_pad_last", {127'd0, pad_last}, 128'd0);
        chk("rst_pad_data", pad_data, 128'd0);
        chk("rst_aes_state", aes_state, 128'd0);
        chk("rst_aes_key", aes_key, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", {127'd0, req_ready}, 128'd1);

        // FIPS-197 vector: exact latency and known ciphertext
        do_req(fips_iv, fips_key, 1);
        lat = 1;
        while (!pad_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("fips_latency", 128'(lat), 128'd14);
        chk("fips_pad", pad_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("fips_last", {127'd0, pad_last}, 128'd1);
        step();
        chk("fips_busy_fall", {127'd0, busy}, 128'd0);
        wait_idle("fips");

        // Counter wrap: consecutive aes_state values
        iv = 128'hA5A5A5A5A5A5A5A5_FFFFFFFFFFFFFFFE;
        do_req(iv, fips_key, 3);
        step();
        chk("wrap_s0", aes_state, 128'hA5A5A5A5A5A5A5A5_FFFFFFFFFFFFFFFE);
        step();
        chk("wrap_s1", aes_state, 128'hA5A5A5A5A5A5A5A5_FFFFFFFFFFFFFFFF);
        step();
        chk("wrap_s2", aes_state, 128'hA5A5A5A5A5A5A5A5_0000000000000000);
        wait_idle("wrap");

        // Table-driven requests
        for (int v = 0; v < 5; v++) begin
            do_req(vt[v].iv, vt[v].key, int'(vt[v].cnt));
            repeat (int'(vt[v].cnt)) step();
            chk("tbl_last_state", aes_state, vt[v].exp_last_state);
            chk("tbl_key", aes_key, vt[v].key);
            wait_idle("tbl");
        end

        // Backpressure: credits stop issue at FIFO_DEPTH
        pad_ready = 1'b0;
        iv = 128'h0F0E0D0C0B0A0908_0000000000001000;
        prev = aes_state;
        issues = 0;
        do_req(iv, fips_key, 40);
        for (int i = 0; i < 40; i++) begin
            if (aes_state !== prev) issues++;
            prev = aes_state;
            step();
        end
        chk("bp_issues", 128'(issues), 128'(FIFO_DEPTH));
        chk("bp_hold_state", aes_state, ctr_add(iv, FIFO_DEPTH - 1));
        chk("bp_pad_valid", {127'd0, pad_valid}, 128'd1);
        chk("bp_head0", pad_data, aes_enc(iv, fips_key));
        repeat (5) step();
        chk("bp_head_stable", pad_data, aes_enc(iv, fips_key));
        chk("bp_last_stable", {127'd0, pad_last}, 128'd0);
        pad_ready = 1'b1;
        wait_idle("bp");

        // Back-to-back: second request held valid during the first
        iv = 128'h1111111111111111_0000000000000010;
        req_iv = fips_iv; req_key = fips_key; req_count = CNT_W'(2); req_valid = 1'b1;
        chk("b2b_ready0", {127'd0, req_ready}, 128'd1);
        push_exp(fips_iv, fips_key, 2);
        step();
        req_iv = iv; req_count = CNT_W'(3);
        push_exp(iv, fips_key, 3);
        n = 0;
        while (!req_ready && n < 10) begin
            step();
            n++;
        end
        chk("b2b_accept_gap", 128'(n), 128'd2);
        step();
        req_valid = 1'b0;
        wait_idle("b2b");
        exp_hold = ctr_add(iv, 2);

        // Zero count: handshake only
        req_iv = 128'h77; req_key = 128'h88; req_count = '0; req_valid = 1'b1;
        chk("zero_ready", {127'd0, req_ready}, 128'd1);
        step();
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (pad_valid || busy || !req_ready || aes_state !== exp_hold) seen++;
            step();
        end
        chk("zero_quiet_cycles", 128'(seen), 128'd0);
        chk("zero_hold_state", aes_state, exp_hold);

        // Reset mid-flight
        iv = 128'h2222222222222222_0000000000000100;
        do_req(iv, fips_key, 20);
        repeat (10) step();
        chk("mid_state10", aes_state, ctr_add(iv, 9));
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        chk("mid_rst_pad_valid", {127'd0, pad_valid}, 128'd0);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_state", aes_state, 128'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (pad_valid) seen++;
            step();
        end
        chk("mid_no_junk", 128'(seen), 128'd0);
        do_req(fips_iv, fips_key, 1);
        wait_idle("mid_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
